// File: rtl/demux_pkg.sv
// demux_pkg: shared widths and types for the 1-to-8 demultiplexer
package demux_pkg;
  localparam int SEL_W = 3;
  localparam int N_OUT = 8;
  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [N_OUT-1:0] dvec_t;
endpackage

// File: rtl/demultiplexer_decoder_3to8.sv
// decoder_3to8: combinational binary-to-one-hot select decoder
module decoder_3to8
  import demux_pkg::*;
(
  input  logic [SEL_W-1:0] sel,
  output logic [N_OUT-1:0] dec
);
  always_comb dec = dvec_t'(1) << sel;
endmodule

// File: rtl/demultiplexer.sv
// demultiplexer: 1-to-8 demux with registered outputs; DEMUX_SEL_OUT_EN adds registered sel_q
module demultiplexer
  import demux_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic in,
  input  logic s0,
  input  logic s1,
  input  logic s2,
  output logic d0,
  output logic d1,
  output logic d2,
  output logic d3,
  output logic d4,
  output logic d5,
  output logic d6,
  output logic d7
`ifdef DEMUX_SEL_OUT_EN
  ,output logic [SEL_W-1:0] sel_q
`endif
);
  sel_t  sel;
  dvec_t dec;
  dvec_t dq;
  assign sel = {s2, s1, s0};
  decoder_3to8 u_dec (
    .sel(sel),
    .dec(dec)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dq <= '0;
    else     dq <= dec & {N_OUT{in}};
  end
  assign {d7, d6, d5, d4, d3, d2, d1, d0} = dq;
`ifdef DEMUX_SEL_OUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sel_q <= '0;
    else     sel_q <= sel;
  end
`endif
endmodule

// File: tb/tb_demultiplexer.sv
// tb_demultiplexer: directed self-checking bench for demultiplexer (honours DEMUX_SEL_OUT_EN)
module tb_demultiplexer;
  logic clk = 1'b0;
  logic rst, in, s0, s1, s2;
  logic d0, d1, d2, d3, d4, d5, d6, d7;
  logic [7:0] d;
  int pass = 0;
  int fail = 0;
  int total = 0;
`ifdef DEMUX_SEL_OUT_EN
  logic [2:0] sel_q;
`endif
  demultiplexer dut (
    .clk(clk), .rst(rst), .in(in), .s0(s0), .s1(s1), .s2(s2),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7)
`ifdef DEMUX_SEL_OUT_EN
    ,.sel_q(sel_q)
`endif
  );
  always #5 clk = ~clk;
  assign d = {d7, d6, d5, d4, d3, d2, d1, d0};
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) pass++;
    else begin
      fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic i, input logic [2:0] s);
    @(negedge clk);
    in = i;
    {s2, s1, s0} = s;
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    in = 1'b1;
    {s2, s1, s0} = 3'd5;
    #1;
    chk("reset_async", d, 8'h00);
    step;
    step;
    chk("reset_held", d, 8'h00);
`ifdef DEMUX_SEL_OUT_EN
    chk("reset_selq", {5'd0, sel_q}, 8'h00);
`endif
    drive(1'b0, 3'd0);
    rst = 1'b0;
    repeat (10) step;
    chk("idle", d, 8'h00);
    drive(1'b1, 3'd2);
    #1;
    chk("route_before_edge", d, 8'h00);
    step;
    chk("route_d2", d, 8'h04);
`ifdef DEMUX_SEL_OUT_EN
    chk("route_selq", {5'd0, sel_q}, 8'h02);
`endif
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 3'(k));
      step;
      chk($sformatf("sweep_%0d", k), d, 8'h01 << k);
`ifdef DEMUX_SEL_OUT_EN
      chk($sformatf("sweep_selq_%0d", k), {5'd0, sel_q}, 8'(k));
`endif
    end
    drive(1'b1, 3'd7);
    step;
    chk("gate_1a", d, 8'h80);
    drive(1'b0, 3'd7);
    step;
    chk("gate_0", d, 8'h00);
`ifdef DEMUX_SEL_OUT_EN
    chk("gate_selq_in0", {5'd0, sel_q}, 8'h07);
`endif
    drive(1'b1, 3'd7);
    step;
    chk("gate_1b", d, 8'h80);
    drive(1'b1, 3'd3);
    step;
    chk("midrst_pre", d, 8'h08);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_async", d, 8'h00);
`ifdef DEMUX_SEL_OUT_EN
    chk("midrst_selq", {5'd0, sel_q}, 8'h00);
`endif
    rst = 1'b0;
    #2;
    chk("midrst_hold_until_edge", d, 8'h00);
    step;
    chk("midrst_restore", d, 8'h08);
    drive(1'b1, 3'd6);
    #1;
    chk("change_between_edges", d, 8'h08);
    step;
    chk("route_d6", d, 8'h40);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
